// File: rtl/addr_mgr_mq_pkg.sv
// rtl/addr_mgr_mq_pkg.sv - shared FSM encodings, default parameters and width helper for addr_manager_mq
package addr_mgr_mq_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_ADDR_WIDTH            = 12;
  localparam int DEF_ADDR_TABLE_DEPTH      = 4096;
  localparam int DEF_NUM_QUEUES            = 4;
  localparam int DEF_QID_WIDTH             = 2;
  localparam int DEF_THRESHOLD_ALMOST_FULL = 48;

  // Free-space and queue-length counters must hold the full depth, hence one extra bit.
  function automatic int remain_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/addr_manager_mq_next_table.sv
// rtl/addr_manager_mq_next_table.sv - next-pointer table, one write port and two async read ports
module addr_next_table #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [ADDR_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr0,
  output logic [ADDR_WIDTH-1:0] rdata0,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [ADDR_WIDTH-1:0] rdata1
);

  // Contents are undefined until the owner's INIT sweep has rewritten every entry.
  logic [ADDR_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/addr_manager_mq.sv
// rtl/addr_manager_mq.sv - multi-queue buffer address manager (free list + per-queue linked lists)
// Optional per-queue length outputs when ADDR_MGR_MQ_QLEN_EN is defined.
module addr_manager_mq
  import addr_mgr_mq_pkg::*;
#(
  parameter int ADDR_WIDTH            = DEF_ADDR_WIDTH,
  parameter int ADDR_TABLE_DEPTH      = DEF_ADDR_TABLE_DEPTH,
  parameter int NUM_QUEUES            = DEF_NUM_QUEUES,
  parameter int QID_WIDTH             = DEF_QID_WIDTH,
  parameter int THRESHOLD_ALMOST_FULL = DEF_THRESHOLD_ALMOST_FULL
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_axis_enq_valid,
  input  logic [QID_WIDTH-1:0]  s_axis_enq_qid,
  output logic                  s_axis_enq_ready,
  output logic [ADDR_WIDTH-1:0] m_axis_enq_addr,
  input  logic                  s_axis_deq_valid,
  input  logic [QID_WIDTH-1:0]  s_axis_deq_qid,
  output logic                  s_axis_deq_ready,
  output logic [ADDR_WIDTH-1:0] m_axis_deq_addr,
  output logic                  m_axis_deq_err,
  output logic [NUM_QUEUES-1:0] m_axis_q_empty,
  output logic [ADDR_WIDTH:0]   m_axis_remain_space,
  output logic                  m_axis_almost_full,
`ifdef ADDR_MGR_MQ_QLEN_EN
  output logic [NUM_QUEUES*(ADDR_WIDTH+1)-1:0] m_axis_qlen,
`endif
  output logic                  m_axis_init_done
);

  localparam int RW = remain_width(ADDR_WIDTH);

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [ADDR_WIDTH-1:0] fl_head, fl_tail;
  logic [RW-1:0]         remain;
  logic [ADDR_WIDTH-1:0] qhead [NUM_QUEUES];
  logic [ADDR_WIDTH-1:0] qtail [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] q_empty;
  logic                  deq_err, init_done;
  logic [ADDR_WIDTH-1:0] fl_next, q_next;
  logic                  tbl_we;
  logic [ADDR_WIDTH-1:0] tbl_waddr, tbl_wdata;
  logic                  enq_fire, deq_fire, deq_ok, init_last;
  logic [ADDR_WIDTH-1:0] deq_head;

  assign deq_head  = qhead[s_axis_deq_qid];
  assign init_last = (init_cnt == ADDR_WIDTH'(ADDR_TABLE_DEPTH - 1));

  // Dequeue wins a same-cycle conflict by withdrawing enqueue readiness.
  assign s_axis_deq_ready = (state == ST_RUN);
  assign s_axis_enq_ready = (state == ST_RUN) && (remain != '0) && !s_axis_deq_valid;
  assign enq_fire = s_axis_enq_valid && s_axis_enq_ready;
  assign deq_fire = s_axis_deq_valid && s_axis_deq_ready;
  assign deq_ok   = deq_fire && !q_empty[s_axis_deq_qid];

  assign m_axis_enq_addr     = fl_head;
  assign m_axis_deq_addr     = deq_head;
  assign m_axis_deq_err      = deq_err;
  assign m_axis_q_empty      = q_empty;
  assign m_axis_remain_space = remain;
  assign m_axis_almost_full  = (remain < RW'(THRESHOLD_ALMOST_FULL));
  assign m_axis_init_done    = init_done;

  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = '0;
    if (state == ST_INIT) begin
      tbl_we    = 1'b1;
      tbl_waddr = init_cnt;
      tbl_wdata = init_cnt + 1'b1;
    end else if (deq_ok) begin
      tbl_we    = 1'b1;
      tbl_waddr = fl_tail;
      tbl_wdata = deq_head;
    end else if (enq_fire && !q_empty[s_axis_enq_qid]) begin
      tbl_we    = 1'b1;
      tbl_waddr = qtail[s_axis_enq_qid];
      tbl_wdata = fl_head;
    end
  end

  addr_next_table #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(ADDR_TABLE_DEPTH)) u_next_table (
    .clk    (clk),
    .we     (tbl_we),
    .waddr  (tbl_waddr),
    .wdata  (tbl_wdata),
    .raddr0 (fl_head),
    .rdata0 (fl_next),
    .raddr1 (deq_head),
    .rdata1 (q_next)
  );

`ifdef ADDR_MGR_MQ_QLEN_EN
  logic [RW-1:0] qlen [NUM_QUEUES];
  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_qlen
    assign m_axis_qlen[g*RW +: RW] = qlen[g];
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      remain    <= '0;
      q_empty   <= '1;
      deq_err   <= 1'b0;
      fl_head   <= '0;
      fl_tail   <= '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        qhead[i] <= '0;
        qtail[i] <= '0;
`ifdef ADDR_MGR_MQ_QLEN_EN
        qlen[i]  <= '0;
`endif
      end
    end else begin
      deq_err <= deq_fire && q_empty[s_axis_deq_qid];
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_last) begin
          fl_head   <= '0;
          fl_tail   <= ADDR_WIDTH'(ADDR_TABLE_DEPTH - 1);
          remain    <= RW'(ADDR_TABLE_DEPTH);
          state     <= ST_RUN;
          init_done <= 1'b1;
        end
      end else if (deq_ok) begin
        remain  <= remain + 1'b1;
        fl_tail <= deq_head;
        // An exhausted free list has no valid head, so the freed word becomes it.
        if (remain == '0) fl_head <= deq_head;
        if (deq_head == qtail[s_axis_deq_qid]) q_empty[s_axis_deq_qid] <= 1'b1;
        else qhead[s_axis_deq_qid] <= q_next;
`ifdef ADDR_MGR_MQ_QLEN_EN
        qlen[s_axis_deq_qid] <= qlen[s_axis_deq_qid] - 1'b1;
`endif
      end else if (enq_fire) begin
        fl_head <= fl_next;
        remain  <= remain - 1'b1;
        if (q_empty[s_axis_enq_qid]) begin
          qhead[s_axis_enq_qid]   <= fl_head;
          q_empty[s_axis_enq_qid] <= 1'b0;
        end
        qtail[s_axis_enq_qid] <= fl_head;
`ifdef ADDR_MGR_MQ_QLEN_EN
        qlen[s_axis_enq_qid] <= qlen[s_axis_enq_qid] + 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_addr_manager_mq.sv
// tb/tb_addr_manager_mq.sv - directed self-checking bench for addr_manager_mq
module tb_addr_manager_mq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enq_valid = 1'b0, deq_valid = 1'b0;
  logic [1:0]  enq_qid = '0, deq_qid = '0;
  logic        enq_ready, deq_ready, deq_err, almost_full, init_done;
  logic [11:0] enq_addr, deq_addr;
  logic [3:0]  q_empty;
  logic [12:0] remain;
`ifdef ADDR_MGR_MQ_QLEN_EN
  logic [51:0] qlen;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  addr_manager_mq dut (
    .clk                 (clk),
    .rstn                (rstn),
    .s_axis_enq_valid    (enq_valid),
    .s_axis_enq_qid      (enq_qid),
    .s_axis_enq_ready    (enq_ready),
    .m_axis_enq_addr     (enq_addr),
    .s_axis_deq_valid    (deq_valid),
    .s_axis_deq_qid      (deq_qid),
    .s_axis_deq_ready    (deq_ready),
    .m_axis_deq_addr     (deq_addr),
    .m_axis_deq_err      (deq_err),
    .m_axis_q_empty      (q_empty),
    .m_axis_remain_space (remain),
    .m_axis_almost_full  (almost_full),
`ifdef ADDR_MGR_MQ_QLEN_EN
    .m_axis_qlen         (qlen),
`endif
    .m_axis_init_done    (init_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic enq(input logic [1:0] q, input int exp_addr);
    enq_valid = 1'b1; enq_qid = q;
    #1;
    check("enq_ready", 32'(enq_ready), 1);
    check("enq_addr", 32'(enq_addr), exp_addr);
    @(posedge clk); #1;
    enq_valid = 1'b0;
  endtask

  task automatic deq(input logic [1:0] q, input int exp_addr);
    deq_valid = 1'b1; deq_qid = q;
    #1;
    check("deq_ready", 32'(deq_ready), 1);
    check("deq_addr", 32'(deq_addr), exp_addr);
    @(posedge clk); #1;
    deq_valid = 1'b0;
    check("deq_err_clear", 32'(deq_err), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_init_done", 32'(init_done), 0);
    check("rst_remain", 32'(remain), 0);
    check("rst_almost_full", 32'(almost_full), 1);
    check("rst_q_empty", 32'(q_empty), 4'hf);
    check("rst_enq_ready", 32'(enq_ready), 0);
    check("rst_deq_ready", 32'(deq_ready), 0);
    check("rst_deq_err", 32'(deq_err), 0);

    // 1: initialisation length
    rstn = 1'b1;
    wait_init(cyc);
    check("init_cycles", cyc, 4096);
    check("init_remain", 32'(remain), 4096);
    check("init_q_empty", 32'(q_empty), 4'hf);
    check("init_almost_full", 32'(almost_full), 0);
    check("init_enq_ready", 32'(enq_ready), 1);

    // 2: three enqueues to q0
    for (int i = 0; i < 3; i++) enq(2'd0, i);
    check("q0_remain", 32'(remain), 4093);
    check("q0_empty", 32'(q_empty), 4'he);

    // 3: drain q0 in FIFO order; freed words go to the free-list tail
    for (int i = 0; i < 3; i++) deq(2'd0, i);
    check("q0_drained_empty", 32'(q_empty), 4'hf);
    check("q0_drained_remain", 32'(remain), 4096);
    enq(2'd1, 3);

    // 4: simultaneous enq/deq on q1 -> deq wins, enq follows next cycle
    enq_valid = 1'b1; enq_qid = 2'd1;
    deq_valid = 1'b1; deq_qid = 2'd1;
    #1;
    check("both_enq_ready", 32'(enq_ready), 0);
    check("both_deq_ready", 32'(deq_ready), 1);
    check("both_deq_addr", 32'(deq_addr), 3);
    @(posedge clk); #1;
    deq_valid = 1'b0;
    #1;
    check("late_enq_ready", 32'(enq_ready), 1);
    check("late_enq_addr", 32'(enq_addr), 4);
    @(posedge clk); #1;
    enq_valid = 1'b0;
    check("q1_remain", 32'(remain), 4095);
    deq(2'd1, 4);
    check("q1_empty", 32'(q_empty), 4'hf);

    // 5: fill completely through q2; free list now starts at 5 and wraps
    for (int i = 1; i <= 4096; i++) begin
      enq(2'd2, (i + 4) % 4096);
      if (i == 4048) check("af_at_48", 32'(almost_full), 0);
      if (i == 4049) check("af_at_47", 32'(almost_full), 1);
    end
    check("full_remain", 32'(remain), 0);
    enq_valid = 1'b1; enq_qid = 2'd3;
    #1;
    check("full_enq_ready", 32'(enq_ready), 0);
    @(posedge clk); #1;
    enq_valid = 1'b0;
    check("full_remain_hold", 32'(remain), 0);
    check("full_q3_empty", 32'(q_empty[3]), 1);
    deq(2'd2, 5);
    check("refree_remain", 32'(remain), 1);
    enq(2'd3, 5);
    check("reuse_remain", 32'(remain), 0);
    deq(2'd3, 5);
    deq(2'd2, 6);
    check("q3_empty_again", 32'(q_empty), 4'hb);

    // 6: dequeue from empty q3
    deq_valid = 1'b1; deq_qid = 2'd3;
    @(posedge clk); #1;
    deq_valid = 1'b0;
    check("err_pulse", 32'(deq_err), 1);
    check("err_remain", 32'(remain), 2);
    @(posedge clk); #1;
    check("err_pulse_end", 32'(deq_err), 0);

    // Async reset mid-traffic
    enq_valid = 1'b1; enq_qid = 2'd2;
    #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_init_done", 32'(init_done), 0);
    check("mid_rst_enq_ready", 32'(enq_ready), 0);
    check("mid_rst_remain", 32'(remain), 0);
    check("mid_rst_q_empty", 32'(q_empty), 4'hf);
    enq_valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    wait_init(cyc);
    check("reinit_cycles", cyc, 4096);
    check("reinit_remain", 32'(remain), 4096);
    enq(2'd0, 0);
    enq(2'd0, 1);
    deq(2'd0, 0);
    deq(2'd0, 1);
    check("reinit_q_empty", 32'(q_empty), 4'hf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
